// File: rtl/dds_sweep_if.sv
// dds_sweep_if: config handshake, run/abort control and DDS drive signals of the sweep sequencer
interface dds_sweep_if #(
    parameter int PHASE_W = 24,
    parameter int DWELL_W = 20
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PHASE_W-1:0] cfg_start;
    logic [PHASE_W-1:0] cfg_stop;
    logic [PHASE_W-1:0] cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [PHASE_W-1:0] cfg_phase;
    logic               cfg_loop;
    logic               run;
    logic               abort;
    logic [PHASE_W-1:0] freq_word;
    logic [PHASE_W-1:0] phase_shift;
    logic               dds_clken;
    logic               busy;
    logic               step_strobe;
    logic               sweep_done;
    modport master (
        output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_phase, cfg_loop, run, abort,
        input  cfg_ready, freq_word, phase_shift, dds_clken, busy, step_strobe, sweep_done
    );
    modport slave (
        input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_phase, cfg_loop, run, abort,
        output cfg_ready, freq_word, phase_shift, dds_clken, busy, step_strobe, sweep_done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: steps the DDS frequency word from start to stop with a per-point dwell.
// Define SWEEP_BIDIR_EN to descend back to start after the stop point (triangle sweep).
module dds_sweep_ctrl #(
    parameter int PHASE_W   = 24,
    parameter int DWELL_W   = 20,
    parameter int CLKEN_DIV = 1
) (
    input logic        clk,
    input logic        rst,
    dds_sweep_if.slave bus
);
    localparam int CW = $clog2(CLKEN_DIV + 1);
    typedef enum logic [1:0] {IDLE, DWELL, STEP, DONE} state_t;
    state_t             state;
    logic [PHASE_W-1:0] start_r, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r, cnt;
    logic               loop_r, last;
    logic [CW-1:0]      div, div_nxt;
    logic               hs, go, stop_now, up_last;
    logic [PHASE_W-1:0] start_e, stop_e, step_e;
    logic [DWELL_W-1:0] dwell_e;
    logic [PHASE_W:0]   up;
`ifdef SWEEP_BIDIR_EN
    logic               dir, dn_last;
    logic [PHASE_W:0]   dn;
`endif

    // a zero dwell still holds the point for one cycle
    function automatic logic [DWELL_W-1:0] ld(input logic [DWELL_W-1:0] d);
        return d == '0 ? '0 : d - 1'b1;
    endfunction

    always_comb begin
        hs       = bus.cfg_valid && bus.cfg_ready;
        start_e  = hs ? bus.cfg_start : start_r;
        stop_e   = hs ? bus.cfg_stop : stop_r;
        step_e   = hs ? bus.cfg_step : step_r;
        dwell_e  = hs ? bus.cfg_dwell : dwell_r;
        go       = state == IDLE && bus.run && !bus.abort;
        stop_now = state != IDLE && bus.abort;
        up       = {1'b0, bus.freq_word} + {1'b0, step_r};
        up_last  = up >= {1'b0, stop_r};
        div_nxt  = div == CW'(CLKEN_DIV - 1) ? '0 : div + 1'b1;
`ifdef SWEEP_BIDIR_EN
        dn       = {1'b0, bus.freq_word} - {1'b0, step_r};
        dn_last  = dn[PHASE_W] || dn[PHASE_W-1:0] <= start_r;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            {start_r, stop_r, step_r, dwell_r, loop_r} <= '0;
            cnt             <= '0;
            last            <= 1'b0;
            div             <= '0;
            bus.cfg_ready   <= 1'b0;
            bus.freq_word   <= '0;
            bus.phase_shift <= '0;
            bus.dds_clken   <= 1'b0;
            bus.busy        <= 1'b0;
            bus.step_strobe <= 1'b0;
            bus.sweep_done  <= 1'b0;
`ifdef SWEEP_BIDIR_EN
            dir             <= 1'b0;
`endif
        end else begin
            bus.step_strobe <= 1'b0;
            bus.sweep_done  <= 1'b0;
            div             <= div_nxt;
            bus.dds_clken   <= div_nxt == '0;
            if (hs) begin
                {start_r, stop_r, step_r, dwell_r, loop_r} <=
                    {bus.cfg_start, bus.cfg_stop, bus.cfg_step, bus.cfg_dwell, bus.cfg_loop};
                bus.phase_shift <= bus.cfg_phase;
            end
            if (stop_now) begin
                state         <= IDLE;
                bus.busy      <= 1'b0;
                bus.cfg_ready <= 1'b1;
                bus.dds_clken <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        div           <= '0;
                        bus.dds_clken <= go;
                        bus.busy      <= go;
                        bus.cfg_ready <= !go;
                        if (go) begin
                            state           <= DWELL;
                            bus.freq_word   <= start_e;
                            bus.step_strobe <= 1'b1;
                            cnt             <= ld(dwell_e);
                            last            <= start_e >= stop_e || step_e == '0;
`ifdef SWEEP_BIDIR_EN
                            dir             <= 1'b0;
`endif
                        end
                    end
                    DWELL: begin
                        if (cnt != '0) cnt <= cnt - 1'b1;
                        else if (!last) state <= STEP;
                        else if (loop_r) begin
                            bus.freq_word   <= start_r;
                            bus.step_strobe <= 1'b1;
                            cnt             <= ld(dwell_r);
                            last            <= start_r >= stop_r || step_r == '0;
`ifdef SWEEP_BIDIR_EN
                            dir             <= 1'b0;
`endif
                        end else begin
                            state          <= DONE;
                            bus.sweep_done <= 1'b1;
                        end
                    end
                    STEP: begin
                        state           <= DWELL;
                        bus.step_strobe <= 1'b1;
                        cnt             <= ld(dwell_r);
`ifdef SWEEP_BIDIR_EN
                        if (dir) begin
                            bus.freq_word <= dn_last ? start_r : dn[PHASE_W-1:0];
                            last          <= dn_last;
                        end else begin
                            bus.freq_word <= up_last ? stop_r : up[PHASE_W-1:0];
                            dir           <= up_last;
                        end
`else
                        bus.freq_word <= up_last ? stop_r : up[PHASE_W-1:0];
                        last          <= up_last;
`endif
                    end
                    DONE: begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.cfg_ready <= 1'b1;
                        bus.dds_clken <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
